// File: rtl/i2c_xfer_seq_pkg.sv
// Shared types for the I2C register-transaction sequencer: FSM states,
// response error codes and the default transaction size.
package i2c_xfer_seq_pkg;

    localparam int I2C_SEQ_MAX_BYTES = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_W,
        ST_REG,
        ST_DATA_W,
        ST_DEV_R,
        ST_DATA_R,
        ST_STOP,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        I2C_SEQ_OK   = 2'b00,
        I2C_SEQ_NACK = 2'b01,
        I2C_SEQ_AL   = 2'b10,
        I2C_SEQ_TMO  = 2'b11
    } seq_err_e;

    // States in which a byte command is outstanding at the byte controller.
    function automatic logic is_cmd_state(seq_state_e s);
        return s inside {ST_DEV_W, ST_REG, ST_DATA_W, ST_DEV_R, ST_DATA_R, ST_STOP};
    endfunction

    // Commands whose received ACK bit comes from the slave.
    function automatic logic is_write_cmd(seq_state_e s);
        return s inside {ST_DEV_W, ST_REG, ST_DATA_W, ST_DEV_R};
    endfunction

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Request/response handshake plus byte-controller command bus of the sequencer.
// The master modport is the sequencer's view; slave is the requester/controller side.
interface i2c_xfer_seq_if #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_rnw_i;
    logic [6:0]             req_dev_i;
    logic [7:0]             req_reg_i;
    logic [LEN_W-1:0]       req_len_i;
    logic [8*MAX_BYTES-1:0] req_wdata_i;
    logic                   rsp_valid_o;
    logic [1:0]             rsp_err_o;
    logic [8*MAX_BYTES-1:0] rsp_rdata_o;
    logic                   start_o;
    logic                   stop_o;
    logic                   read_o;
    logic                   write_o;
    logic                   ack_o;
    logic [7:0]             dat_o;
    logic                   cmd_ack_i;
    logic                   ack_i;
    logic [7:0]             dat_i;
    logic                   al_i;

    modport master (
        input  req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_len_i, req_wdata_i,
        input  cmd_ack_i, ack_i, dat_i, al_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output start_o, stop_o, read_o, write_o, ack_o, dat_o
    );

    modport slave (
        output req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_len_i, req_wdata_i,
        output cmd_ack_i, ack_i, dat_i, al_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  start_o, stop_o, read_o, write_o, ack_o, dat_o
    );
endinterface

// File: rtl/i2c_xfer_seq_wdog.sv
// Per-command watchdog: reloads while load_i is high, otherwise counts down and
// flags expiry on the TIMEOUT_CYC-th consecutive non-load cycle.
module i2c_seq_wdog
    import i2c_xfer_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = !load_i && (cnt_q == '0);
endmodule

// File: rtl/i2c_xfer_seq.sv
// Register-transaction sequencer: turns one write/read register request into
// start/write/read/stop byte commands for the I2C byte controller.
module i2c_xfer_seq
    import i2c_xfer_seq_pkg::*;
#(
    parameter int MAX_BYTES   = I2C_SEQ_MAX_BYTES,
    parameter int TIMEOUT_CYC = 65535,
    parameter int LEN_W       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           ena_i,
    i2c_xfer_seq_if.master bus
);
    localparam int DW = 8 * MAX_BYTES;

    seq_state_e       state_q, state_d, follow_q, follow_d;
    seq_err_e         err_q, err_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             rnw_q, rnw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       sub_q, sub_d;
    logic [DW-1:0]    wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic             start_q, start_d, stop_q, stop_d, read_q, read_d;
    logic             write_q, write_d, ack_q, ack_d;
    logic [7:0]       dat_q, dat_d;
    logic             wdog_exp;

    i2c_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (!is_cmd_state(state_q)),
        .expired_o (wdog_exp)
    );

    // Next state first, then all registered outputs are derived from the next
    // state so strobes line up with the cycle the FSM enters a command state.
    always_comb begin
        state_d     = state_q;
        follow_d    = follow_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        rnw_d       = rnw_q;
        dev_d       = dev_q;
        sub_d       = sub_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    state_d = ST_DEV_W;
                    err_d   = I2C_SEQ_OK;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    rnw_d   = bus.req_rnw_i;
                    dev_d   = bus.req_dev_i;
                    sub_d   = bus.req_reg_i;
                    len_d   = bus.req_len_i;
                    wdata_d = bus.req_wdata_i;
                end
            end
            ST_GAP:  state_d = follow_q;
            ST_DONE: state_d = ST_IDLE;
            ST_DEV_W, ST_REG, ST_DATA_W, ST_DEV_R, ST_DATA_R, ST_STOP: begin
                if (bus.cmd_ack_i) begin
                    state_d = ST_GAP;
                    if (is_write_cmd(state_q) && bus.ack_i) begin
                        err_d    = I2C_SEQ_NACK;
                        follow_d = ST_STOP;
                    end else begin
                        case (state_q)
                            ST_DEV_W: follow_d = ST_REG;
                            ST_REG:   follow_d = rnw_q ? ST_DEV_R : ST_DATA_W;
                            ST_DEV_R: follow_d = ST_DATA_R;
                            ST_DATA_W, ST_DATA_R: begin
                                if (state_q == ST_DATA_R) begin
                                    rbuf_d[{cnt_q, 3'b000} +: 8] = bus.dat_i;
                                end
                                if (cnt_q == len_q) begin
                                    follow_d = ST_STOP;
                                end else begin
                                    follow_d = state_q;
                                    cnt_d    = cnt_q + LEN_W'(1);
                                end
                            end
                            default: state_d = ST_DONE;
                        endcase
                    end
                end else if (wdog_exp) begin
                    state_d = ST_DONE;
                    err_d   = I2C_SEQ_TMO;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Arbitration loss abandons the bus immediately, so no STOP is issued.
        if (bus.al_i && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_DONE;
            err_d   = I2C_SEQ_AL;
        end

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            rsp_rdata_d = rbuf_d;
        end

        if (!ena_i) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_err_d   = rsp_err_q;
            rsp_rdata_d = rsp_rdata_q;
        end

        req_ready_d = (state_d == ST_IDLE) && ena_i;
        start_d     = (state_d == ST_DEV_W) || (state_d == ST_DEV_R);
        write_d     = is_write_cmd(state_d);
        read_d      = (state_d == ST_DATA_R);
        stop_d      = (state_d == ST_STOP);
        ack_d       = (state_d == ST_DATA_R) && (cnt_d == len_d);
        case (state_d)
            ST_DEV_W:  dat_d = {dev_d, 1'b0};
            ST_REG:    dat_d = sub_d;
            ST_DATA_W: dat_d = wdata_d[{cnt_d, 3'b000} +: 8];
            ST_DEV_R:  dat_d = {dev_d, 1'b1};
            default:   dat_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            follow_q    <= ST_IDLE;
            err_q       <= I2C_SEQ_OK;
            cnt_q       <= '0;
            len_q       <= '0;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            sub_q       <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            follow_q    <= follow_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            rnw_q       <= rnw_d;
            dev_q       <= dev_d;
            sub_q       <= sub_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            read_q      <= read_d;
            write_q     <= write_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.start_o     = start_q;
    assign bus.stop_o      = stop_q;
    assign bus.read_o      = read_q;
    assign bus.write_o     = write_q;
    assign bus.ack_o       = ack_q;
    assign bus.dat_o       = dat_q;
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Self-checking bench for i2c_xfer_seq: the bench plays requester and byte
// controller, and predicts each command and response from a transaction-level model.
module tb_i2c_xfer_seq;
    localparam int MB  = 4;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  lastErr   = 2'b00;
    logic [31:0] lastRdata = 32'h0;
    logic [7:0]  slaveBytes[$];

    i2c_xfer_seq_if #(.MAX_BYTES(MB), .LEN_W(2)) bus ();

    i2c_xfer_seq #(.MAX_BYTES(MB), .TIMEOUT_CYC(TMO), .LEN_W(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ena_i   (ena),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] stb();
        return {bus.start_o, bus.stop_o, bus.read_o, bus.write_o, bus.ack_o};
    endfunction

    // kind: 0 clean, 1 NACK at command fidx, 2 arbitration loss, 3 timeout,
    // 4 enable drop, 5 asynchronous reset -- each injected at command index fidx.
    task automatic applyStimulus(input bit rnw, input logic [6:0] dev, input logic [7:0] sub,
                                 input int len, input logic [31:0] wdata,
                                 input int kind, input int fidx);
        logic [4:0]  expStb[$];
        logic [7:0]  expDat[$];
        bit          expChk[$];
        logic [31:0] rbuf   = 32'h0;
        logic [1:0]  errExp = 2'b00;
        logic [7:0]  rb;
        int          idx    = 0;
        int          rdIdx  = 0;
        int          stopIdx;
        int          w      = 0;
        bit          done   = 0;

        expStb.push_back(5'b10010); expDat.push_back({dev, 1'b0}); expChk.push_back(1);
        expStb.push_back(5'b00010); expDat.push_back(sub);         expChk.push_back(1);
        if (!rnw) begin
            for (int n = 0; n <= len; n++) begin
                expStb.push_back(5'b00010); expDat.push_back(wdata[8*n +: 8]); expChk.push_back(1);
            end
        end else begin
            expStb.push_back(5'b10010); expDat.push_back({dev, 1'b1}); expChk.push_back(1);
            for (int n = 0; n <= len; n++) begin
                expStb.push_back({4'b0010, n == len}); expDat.push_back(8'h00); expChk.push_back(0);
            end
        end
        expStb.push_back(5'b01000); expDat.push_back(8'h00); expChk.push_back(0);
        stopIdx = expStb.size() - 1;

        while (bus.req_ready_o !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("req_ready", 64'(bus.req_ready_o), 64'(1));
        bus.req_valid_i = 1'b1;
        bus.req_rnw_i   = rnw;
        bus.req_dev_i   = dev;
        bus.req_reg_i   = sub;
        bus.req_len_i   = 2'(len);
        bus.req_wdata_i = wdata;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_wdata_i = 32'($urandom);
        checkOutput("ready_drop", 64'(bus.req_ready_o), 64'(0));

        while (!done) begin
            checkOutput($sformatf("stb%0d", idx), 64'(stb()), 64'(expStb[idx]));
            if (expChk[idx]) checkOutput($sformatf("dat%0d", idx), 64'(bus.dat_o), 64'(expDat[idx]));
            if (kind == 3 && idx == fidx) begin
                repeat (TMO - 1) begin
                    @(negedge clk);
                    checkOutput("tmo_hold", 64'(stb()), 64'(expStb[idx]));
                end
                @(negedge clk);
                checkOutput("tmo_drop", 64'(stb()), 64'(0));
                checkOutput("tmo_valid", 64'(bus.rsp_valid_o), 64'(1));
                checkOutput("tmo_err", 64'(bus.rsp_err_o), 64'(2'b11));
                errExp = 2'b11;
                done   = 1;
            end else if (kind == 2 && idx == fidx) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    checkOutput("al_hold", 64'(stb()), 64'(expStb[idx]));
                end
                bus.al_i = 1'b1;
                @(negedge clk);
                bus.al_i = 1'b0;
                checkOutput("al_drop", 64'(stb()), 64'(0));
                checkOutput("al_valid", 64'(bus.rsp_valid_o), 64'(1));
                checkOutput("al_err", 64'(bus.rsp_err_o), 64'(2'b10));
                checkOutput("al_rdata", 64'(bus.rsp_rdata_o), 64'(rbuf));
                errExp = 2'b10;
                done   = 1;
            end else if (kind == 4 && idx == fidx) begin
                @(negedge clk);
                checkOutput("ena_hold", 64'(stb()), 64'(expStb[idx]));
                ena = 1'b0;
                @(negedge clk);
                checkOutput("ena_drop", 64'(stb()), 64'(0));
                checkOutput("ena_ready", 64'(bus.req_ready_o), 64'(0));
                checkOutput("ena_err", 64'(bus.rsp_err_o), 64'(lastErr));
                checkOutput("ena_rdata", 64'(bus.rsp_rdata_o), 64'(lastRdata));
                repeat (3) begin
                    checkOutput("ena_novalid", 64'(bus.rsp_valid_o), 64'(0));
                    @(negedge clk);
                end
                ena = 1'b1;
                @(negedge clk);
                checkOutput("ena_ready_back", 64'(bus.req_ready_o), 64'(1));
                checkOutput("ena_novalid_end", 64'(bus.rsp_valid_o), 64'(0));
                return;
            end else if (kind == 5 && idx == fidx) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("rst_stb", 64'(stb()), 64'(0));
                checkOutput("rst_dat", 64'(bus.dat_o), 64'(0));
                checkOutput("rst_ready", 64'(bus.req_ready_o), 64'(0));
                checkOutput("rst_valid", 64'(bus.rsp_valid_o), 64'(0));
                checkOutput("rst_err", 64'(bus.rsp_err_o), 64'(0));
                checkOutput("rst_rdata", 64'(bus.rsp_rdata_o), 64'(0));
                lastErr   = 2'b00;
                lastRdata = 32'h0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checkOutput("rst_ready_back", 64'(bus.req_ready_o), 64'(1));
                checkOutput("rst_novalid", 64'(bus.rsp_valid_o), 64'(0));
                return;
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    checkOutput("hold", 64'(stb()), 64'(expStb[idx]));
                end
                bus.cmd_ack_i = 1'b1;
                bus.ack_i     = (kind == 1 && idx == fidx);
                if (expStb[idx][2]) begin
                    if (slaveBytes.size() > 0) rb = slaveBytes.pop_front();
                    else rb = 8'($urandom);
                    bus.dat_i = rb;
                    rbuf[8*rdIdx +: 8] = rb;
                    rdIdx++;
                end else begin
                    bus.dat_i = 8'($urandom);
                end
                @(negedge clk);
                bus.cmd_ack_i = 1'b0;
                bus.ack_i     = 1'b0;
                bus.dat_i     = 8'h00;
                checkOutput("gap", 64'(stb()), 64'(0));
                if (idx == stopIdx) begin
                    checkOutput("rsp_valid", 64'(bus.rsp_valid_o), 64'(1));
                    checkOutput("rsp_err", 64'(bus.rsp_err_o), 64'(errExp));
                    checkOutput("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(rbuf));
                    done = 1;
                end else begin
                    checkOutput("no_valid", 64'(bus.rsp_valid_o), 64'(0));
                    if (kind == 1 && idx == fidx) begin
                        errExp = 2'b01;
                        idx    = stopIdx;
                    end else begin
                        idx++;
                    end
                    @(negedge clk);
                end
            end
        end

        lastErr   = errExp;
        lastRdata = rbuf;
        @(negedge clk);
        checkOutput("post_valid", 64'(bus.rsp_valid_o), 64'(0));
        checkOutput("post_ready", 64'(bus.req_ready_o), 64'(1));
        checkOutput("post_err", 64'(bus.rsp_err_o), 64'(lastErr));
        checkOutput("post_rdata", 64'(bus.rsp_rdata_o), 64'(lastRdata));
    endtask

    initial begin
        int  len;
        int  kind;
        int  fidx;
        bit  rnw;

        bus.req_valid_i = 1'b0;
        bus.req_rnw_i   = 1'b0;
        bus.req_dev_i   = 7'h00;
        bus.req_reg_i   = 8'h00;
        bus.req_len_i   = 2'd0;
        bus.req_wdata_i = 32'h0;
        bus.cmd_ack_i   = 1'b0;
        bus.ack_i       = 1'b0;
        bus.dat_i       = 8'h00;
        bus.al_i        = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_stb", 64'(stb()), 64'(0));
        checkOutput("reset_dat", 64'(bus.dat_o), 64'(0));
        checkOutput("reset_ready", 64'(bus.req_ready_o), 64'(0));
        checkOutput("reset_valid", 64'(bus.rsp_valid_o), 64'(0));
        checkOutput("reset_err", 64'(bus.rsp_err_o), 64'(0));
        checkOutput("reset_rdata", 64'(bus.rsp_rdata_o), 64'(0));
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(bus.req_ready_o), 64'(1));

        $display("[TB] directed write and read");
        applyStimulus(1'b0, 7'h50, 8'h10, 1, 32'h0000BEEF, 0, 0);
        slaveBytes.push_back(8'h11);
        slaveBytes.push_back(8'h22);
        slaveBytes.push_back(8'h33);
        applyStimulus(1'b1, 7'h50, 8'h20, 2, 32'h0, 0, 0);
        checkOutput("tp_read_rdata", 64'(bus.rsp_rdata_o), 64'(32'h00332211));

        $display("[TB] error cases");
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 3, $urandom, 1, 1);
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 2, $urandom, 2, 3);
        applyStimulus(1'b1, 7'($urandom), 8'($urandom), 1, 32'h0, 3, 0);
        applyStimulus(1'b1, 7'($urandom), 8'($urandom), 3, 32'h0, 4, 4);
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 3, $urandom, 3, 1);
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 3, $urandom, 5, 3);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 12; t++) begin
            rnw  = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            if (kind == 3) kind = 0;
            if (kind == 1) fidx = rnw ? $urandom_range(0, 2) : $urandom_range(0, len + 2);
            else fidx = $urandom_range(0, rnw ? len + 4 : len + 3);
            applyStimulus(rnw, 7'($urandom), 8'($urandom), len, $urandom, kind, fidx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
